// File: rtl/exu_longpwbck_arb.sv
// Long-pipe write-back arbiter: retires channels in OITF order through a one-entry output register.
// Optional stall watchdog enabled by defining LONGPWBCK_WDOG_EN.
module exu_longpwbck_arb #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ITAG_WIDTH  = 2,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned WDOG_LIMIT  = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            ch_wbck_i_valid,
    output logic [NCH-1:0]            ch_wbck_i_ready,
    input  logic [NCH*XLEN-1:0]       ch_wbck_i_wdat,
    input  logic [NCH*ITAG_WIDTH-1:0] ch_wbck_i_itag,
    output logic                      longp_wbck_o_valid,
    input  logic                      longp_wbck_o_ready,
    output logic [XLEN-1:0]           longp_wbck_o_data,
    output logic [RFIDX_WIDTH-1:0]    longp_wbck_o_rdidx,
    input  logic                      oitf_empty,
    input  logic [ITAG_WIDTH-1:0]     oitf_ret_ptr,
    input  logic                      oitf_ret_rdwen,
    input  logic [RFIDX_WIDTH-1:0]    oitf_ret_rdidx,
    output logic                      oitf_ret_ena,
    output logic                      wbck_pend_valid,
    output logic [RFIDX_WIDTH-1:0]    wbck_pend_rdidx,
    output logic                      longp_multi_hit,
    output logic                      longp_wdog_err
);

    logic [NCH-1:0]         hit;
    logic [NCH-1:0]         sel_oh;
    logic [XLEN-1:0]        sel_data;
    logic                   any_hit;
    logic                   multi;
    logic                   can_acc;
    logic                   ret;
    logic                   load;

    logic                   o_valid_q, o_valid_d;
    logic [XLEN-1:0]        o_data_q, o_data_d;
    logic [RFIDX_WIDTH-1:0] o_rdidx_q, o_rdidx_d;
    logic                   multi_q, multi_d;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = ch_wbck_i_valid[i] & ~oitf_empty
                   & (ch_wbck_i_itag[i*ITAG_WIDTH +: ITAG_WIDTH] == oitf_ret_ptr);
        end
    end

    // Lowest set bit isolates the winner; any remaining bit means a second hit.
    assign sel_oh  = hit & ~(hit - NCH'(1));
    assign multi   = |(hit & (hit - NCH'(1)));
    assign any_hit = |hit;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_oh[i]) begin
                sel_data = ch_wbck_i_wdat[i*XLEN +: XLEN];
            end
        end
    end

    assign can_acc = ~o_valid_q | longp_wbck_o_ready;
    // Ops without a destination retire even while the output register is stalled.
    assign ret     = any_hit & (~oitf_ret_rdwen | can_acc);
    assign load    = ret & oitf_ret_rdwen;

    assign oitf_ret_ena    = ret;
    assign ch_wbck_i_ready = ret ? sel_oh : '0;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_rdidx_d = o_rdidx_q;
        multi_d   = multi_q | multi;
        if (load) begin
            o_valid_d = 1'b1;
            o_data_d  = sel_data;
            o_rdidx_d = oitf_ret_rdidx;
        end else if (longp_wbck_o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_rdidx_q <= '0;
            multi_q   <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_rdidx_q <= o_rdidx_d;
            multi_q   <= multi_d;
        end
    end

    assign longp_wbck_o_valid = o_valid_q;
    assign longp_wbck_o_data  = o_data_q;
    assign longp_wbck_o_rdidx = o_rdidx_q;
    assign wbck_pend_valid    = o_valid_q;
    assign wbck_pend_rdidx    = o_rdidx_q;
    assign longp_multi_hit    = multi_q;

`ifdef LONGPWBCK_WDOG_EN
    localparam int unsigned WdogRaw = $clog2(WDOG_LIMIT + 1);
    localparam int unsigned WdogW   = (WdogRaw < 8) ? 8 : ((WdogRaw > 16) ? 16 : WdogRaw);
    localparam logic [WdogW-1:0] WdogLimit = WdogW'(WDOG_LIMIT);

    logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_err_q, wdog_err_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;
        if (oitf_empty | ret) begin
            wdog_cnt_d = '0;
        end else begin
            if (wdog_cnt_q != WdogLimit) begin
                wdog_cnt_d = wdog_cnt_q + WdogW'(1);
            end
            if (wdog_cnt_d == WdogLimit) begin
                wdog_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign longp_wdog_err = wdog_err_q;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign longp_wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_exu_longpwbck_arb.sv
// Bench for exu_longpwbck_arb: vector table, directed corner sequences and a random phase
// checked against a behavioural model of the retire rules.
module tb_exu_longpwbck_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_ready;
    logic [63:0] ch_wdat;
    logic [3:0]  ch_itag;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [4:0]  o_rdidx;
    logic        oitf_empty;
    logic [1:0]  ret_ptr;
    logic        ret_rdwen;
    logic [4:0]  ret_rdidx;
    logic        ret_ena;
    logic        pend_valid;
    logic [4:0]  pend_rdidx;
    logic        multi_hit;
    logic        wdog_err;

    exu_longpwbck_arb #(
        .NCH(2), .XLEN(32), .ITAG_WIDTH(2), .RFIDX_WIDTH(5), .WDOG_LIMIT(4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ch_wbck_i_valid    (ch_valid),
        .ch_wbck_i_ready    (ch_ready),
        .ch_wbck_i_wdat     (ch_wdat),
        .ch_wbck_i_itag     (ch_itag),
        .longp_wbck_o_valid (o_valid),
        .longp_wbck_o_ready (o_ready),
        .longp_wbck_o_data  (o_data),
        .longp_wbck_o_rdidx (o_rdidx),
        .oitf_empty         (oitf_empty),
        .oitf_ret_ptr       (ret_ptr),
        .oitf_ret_rdwen     (ret_rdwen),
        .oitf_ret_rdidx     (ret_rdidx),
        .oitf_ret_ena       (ret_ena),
        .wbck_pend_valid    (pend_valid),
        .wbck_pend_rdidx    (pend_rdidx),
        .longp_multi_hit    (multi_hit),
        .longp_wdog_err     (wdog_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  t0, t1;
        logic [31:0] d0, d1;
        logic        empty;
        logic [1:0]  ptr;
        logic        rdwen;
        logic [4:0]  rdidx;
        logic [1:0]  e_rdy;
        logic        e_ret;
        logic        e_ov;
        logic [31:0] e_data;
        logic [4:0]  e_idx;
    } vec_t;

    vec_t tbl[6];

    // Behavioural model of the output register and sticky error
    logic        mv;
    logic [31:0] md;
    logic [4:0]  mi;
    logic        mm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] t0, input logic [1:0] t1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic empty,
                         input logic [1:0] ptr, input logic rdwen, input logic [4:0] rdidx,
                         input logic ordy);
        ch_valid   = vld;
        ch_itag    = {t1, t0};
        ch_wdat    = {d1, d0};
        oitf_empty = empty;
        ret_ptr    = ptr;
        ret_rdwen  = rdwen;
        ret_rdidx  = rdidx;
        o_ready    = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        logic [1:0]  vld, ptr;
        logic [1:0]  tt[2];
        logic [31:0] dd[2];
        logic        empty, rdwen, ordy, eret;
        logic [4:0]  rdidx;
        logic [1:0]  erdy;
        int          hits[$];
        vld   = 2'($urandom_range(0, 3));
        tt[0] = 2'($urandom_range(0, 3));
        tt[1] = 2'($urandom_range(0, 3));
        dd[0] = $urandom;
        dd[1] = $urandom;
        empty = ($urandom_range(0, 7) == 0);
        ptr   = 2'($urandom_range(0, 3));
        rdwen = ($urandom_range(0, 3) != 0);
        rdidx = 5'($urandom_range(0, 31));
        ordy  = ($urandom_range(0, 9) < 7);
        drive(vld, tt[0], tt[1], dd[0], dd[1], empty, ptr, rdwen, rdidx, ordy);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && tt[i] == ptr && !empty) hits.push_back(i);
        end
        eret = (hits.size() > 0) && (!rdwen || !mv || ordy);
        erdy = eret ? 2'(1 << hits[0]) : 2'b00;
        chk("rand_ready", ch_ready, erdy);
        chk("rand_ret_ena", ret_ena, eret);
        if (eret && rdwen) begin
            mv = 1'b1;
            md = dd[hits[0]];
            mi = rdidx;
        end else if (ordy) begin
            mv = 1'b0;
        end
        if (hits.size() > 1) mm = 1'b1;
        step();
        chk("rand_o_valid", o_valid, mv);
        chk("rand_pend_valid", pend_valid, mv);
        if (mv) begin
            chk("rand_o_data", o_data, md);
            chk("rand_o_rdidx", o_rdidx, mi);
            chk("rand_pend_rdidx", pend_rdidx, mi);
        end
        chk("rand_multi_hit", multi_hit, mm);
    endtask

    initial begin
        logic exp_err;
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1);
        #12;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data", o_data, 32'h0);
        chk("rst_o_rdidx", o_rdidx, 5'd0);
        chk("rst_pend_valid", pend_valid, 1'b0);
        chk("rst_multi_hit", multi_hit, 1'b0);
        chk("rst_wdog_err", wdog_err, 1'b0);
        rst_n = 1'b1;
        step();

        tbl[0] = '{2'b10, 2'd0, 2'd1, 32'h0, 32'hDEADBEEF, 1'b0, 2'd1, 1'b1, 5'd5,
                   2'b10, 1'b1, 1'b1, 32'hDEADBEEF, 5'd5};
        tbl[1] = '{2'b01, 2'd2, 2'd0, 32'h11111111, 32'h0, 1'b0, 2'd2, 1'b1, 5'd7,
                   2'b01, 1'b1, 1'b1, 32'h11111111, 5'd7};
        tbl[2] = '{2'b01, 2'd3, 2'd0, 32'h22222222, 32'h0, 1'b0, 2'd2, 1'b1, 5'd8,
                   2'b00, 1'b0, 1'b0, 32'h0, 5'd0};
        tbl[3] = '{2'b11, 2'd0, 2'd0, 32'h33333333, 32'h44444444, 1'b1, 2'd0, 1'b1, 5'd9,
                   2'b00, 1'b0, 1'b0, 32'h0, 5'd0};
        tbl[4] = '{2'b10, 2'd0, 2'd3, 32'h0, 32'h55555555, 1'b0, 2'd3, 1'b0, 5'd10,
                   2'b10, 1'b1, 1'b0, 32'h0, 5'd0};
        tbl[5] = '{2'b00, 2'd1, 2'd1, 32'h0, 32'h0, 1'b0, 2'd1, 1'b1, 5'd11,
                   2'b00, 1'b0, 1'b0, 32'h0, 5'd0};

        for (int r = 0; r < 6; r++) begin
            drive(tbl[r].vld, tbl[r].t0, tbl[r].t1, tbl[r].d0, tbl[r].d1, tbl[r].empty,
                  tbl[r].ptr, tbl[r].rdwen, tbl[r].rdidx, 1'b1);
            #2;
            chk($sformatf("tbl%0d_ready", r), ch_ready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_ret_ena", r), ret_ena, tbl[r].e_ret);
            step();
            chk($sformatf("tbl%0d_o_valid", r), o_valid, tbl[r].e_ov);
            chk($sformatf("tbl%0d_pend_valid", r), pend_valid, tbl[r].e_ov);
            if (tbl[r].e_ov) begin
                chk($sformatf("tbl%0d_o_data", r), o_data, tbl[r].e_data);
                chk($sformatf("tbl%0d_o_rdidx", r), o_rdidx, tbl[r].e_idx);
                chk($sformatf("tbl%0d_pend_rdidx", r), pend_rdidx, tbl[r].e_idx);
            end
        end
        chk("tbl_multi_hit", multi_hit, 1'b0);

        // Full register stalled with an rd-writing head, then release
        drive(2'b10, 2'd0, 2'd1, 32'h0, 32'hAAAA0001, 1'b0, 2'd1, 1'b1, 5'd3, 1'b1);
        step();
        chk("stall_load_valid", o_valid, 1'b1);
        drive(2'b10, 2'd0, 2'd1, 32'h0, 32'hBBBB0002, 1'b0, 2'd1, 1'b1, 5'd9, 1'b0);
        #2;
        chk("stall_ready", ch_ready, 2'b00);
        chk("stall_ret_ena", ret_ena, 1'b0);
        step();
        step();
        chk("stall_hold_valid", o_valid, 1'b1);
        chk("stall_hold_data", o_data, 32'hAAAA0001);
        chk("stall_hold_rdidx", o_rdidx, 5'd3);
        o_ready = 1'b1;
        #2;
        chk("release_ready", ch_ready, 2'b10);
        chk("release_ret_ena", ret_ena, 1'b1);
        step();
        chk("release_valid", o_valid, 1'b1);
        chk("release_data", o_data, 32'hBBBB0002);
        chk("release_rdidx", o_rdidx, 5'd9);

        // No-rd retire while stalled bypasses the register
        drive(2'b01, 2'd1, 2'd0, 32'hCCCC0003, 32'h0, 1'b0, 2'd1, 1'b0, 5'd12, 1'b0);
        #2;
        chk("nord_ready", ch_ready, 2'b01);
        chk("nord_ret_ena", ret_ena, 1'b1);
        step();
        chk("nord_valid", o_valid, 1'b1);
        chk("nord_data", o_data, 32'hBBBB0002);
        chk("nord_rdidx", o_rdidx, 5'd9);
        o_ready = 1'b1;
        step();
        chk("nord_drain_valid", o_valid, 1'b0);
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b1);
        step();

        mv = 1'b0;
        md = '0;
        mi = '0;
        mm = 1'b0;
        for (int n = 0; n < 400; n++) rand_cycle();

        // Two channels matching the head: channel 0 wins, error is sticky
        drive(2'b11, 2'd2, 2'd2, 32'hC0C0C0C0, 32'hC1C1C1C1, 1'b0, 2'd2, 1'b1, 5'd6, 1'b1);
        #2;
        chk("multi_ready", ch_ready, 2'b01);
        step();
        chk("multi_hit_set", multi_hit, 1'b1);
        chk("multi_data", o_data, 32'hC0C0C0C0);
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1);
        step();
        step();
        chk("multi_hit_sticky", multi_hit, 1'b1);

        // Asynchronous reset with a pending write in the register
        drive(2'b01, 2'd0, 2'd0, 32'h12345678, 32'h0, 1'b0, 2'd0, 1'b1, 5'd4, 1'b0);
        step();
        chk("prerst_valid", o_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_o_valid", o_valid, 1'b0);
        chk("arst_pend_valid", pend_valid, 1'b0);
        chk("arst_o_data", o_data, 32'h0);
        chk("arst_multi_hit", multi_hit, 1'b0);
        chk("arst_wdog_err", wdog_err, 1'b0);
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1);
        step();
        rst_n = 1'b1;

        // Head never matched: watchdog trips after WDOG_LIMIT stall cycles when built in
`ifdef LONGPWBCK_WDOG_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd0, 1'b1);
        step();
        step();
        step();
        chk("wdog_below_limit", wdog_err, 1'b0);
        step();
        chk("wdog_at_limit", wdog_err, exp_err);
        drive(2'b01, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b1);
        step();
        drive(2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1);
        step();
        chk("wdog_sticky", wdog_err, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exu_longpwbck_arb.md
Name: exu_longpwbck_arb

Overview:
Parametrised long-pipe write-back arbiter for NCH long-pipe channels (channel 0 LSU, channel 1 MUL/DIV, further channels reserved).
- Write-back completes strictly in OITF order: only the channel whose itag equals the OITF retire pointer may retire.
- Register write-backs pass through a one-entry output pipeline register toward final write-back.
- Exports the pending-register state so hazard logic can cover the window after OITF pop.

Parameters:
NCH, 2, number of long-pipe channels (1..8)
XLEN, 32, data width
ITAG_WIDTH, 2, OITF tag width
RFIDX_WIDTH, 5, register index width
WDOG_LIMIT, 255, watchdog stall threshold in cycles (used only with LONGPWBCK_WDOG_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_wbck_i_valid  in  NCH  per-channel write-back valid
ch_wbck_i_ready  out  NCH  per-channel ready
ch_wbck_i_wdat  in  NCH*XLEN  packed data, channel i at [i*XLEN +: XLEN]
ch_wbck_i_itag  in  NCH*ITAG_WIDTH  packed itags
longp_wbck_o_valid  out  1  registered write-back valid
longp_wbck_o_ready  in  1  final write-back ready
longp_wbck_o_data  out  XLEN  registered data
longp_wbck_o_rdidx  out  RFIDX_WIDTH  registered destination index
oitf_empty  in  1  OITF empty
oitf_ret_ptr  in  ITAG_WIDTH  itag of OITF head
oitf_ret_rdwen  in  1  head entry writes rd
oitf_ret_rdidx  in  RFIDX_WIDTH  head entry rd
oitf_ret_ena  out  1  pop OITF head
wbck_pend_valid  out  1  output register holds an unretired rd write
wbck_pend_rdidx  out  RFIDX_WIDTH  rd held in output register
longp_multi_hit  out  1  sticky error: more than one channel matched head
longp_wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset state: all registered outputs are 0 (longp_wbck_o_valid, data, rdidx, wbck_pend_*, longp_multi_hit, longp_wdog_err, watchdog counter).
- Channel match:
  - hit[i] = ch_wbck_i_valid[i] & (itag_i == oitf_ret_ptr) & ~oitf_empty.
  - Selected channel is the lowest-index hit.
  - Two or more hits in one cycle set longp_multi_hit (sticky until reset); the lowest index still proceeds.
- Output register accepts a new entry when can_acc = ~longp_wbck_o_valid | longp_wbck_o_ready (full-throughput pipe register, no bubble).
- Retire condition: ret = any_hit & (oitf_ret_rdwen ? can_acc : 1).
  - oitf_ret_ena = ret.
  - ch_wbck_i_ready[sel] = ret; all other ready bits are 0.
  - A non-hit channel never sees ready, even if valid.
- rdwen=1 retire: on the clock edge, the register loads data from the selected channel, rdidx = oitf_ret_rdidx, and valid=1.
- rdwen=0 retire (stores, no-rd ops):
  - The OITF pops without using the register, even when the register is full and stalled.
  - Register contents are unchanged, except valid clears when longp_wbck_o_ready is high.
- Output register drain: valid clears when longp_wbck_o_ready=1 and no new load occurs in the same cycle. Simultaneous drain and load replaces the contents, keeping valid=1.
- Output stability: the output is held stable while valid & ~ready.
- Latency: channel handshake to longp_wbck_o_valid is 1 cycle.
- Pending state: wbck_pend_valid = longp_wbck_o_valid; wbck_pend_rdidx = longp_wbck_o_rdidx. Issue-side hazard logic must OR these with OITF dependency checks.
- OITF empty: no channel is ready and oitf_ret_ena=0. The register still drains normally.
- Reset mid-operation clears the register contents. The pending rd write is dropped; the OITF is reset in the same reset domain.

Optional Feature:
Macro: LONGPWBCK_WDOG_EN.
- Defined:
  - An 8..16-bit counter (width sufficient for WDOG_LIMIT) increments each cycle with ~oitf_empty & ~oitf_ret_ena.
  - The counter clears on oitf_ret_ena or oitf_empty.
  - When the counter reaches WDOG_LIMIT, longp_wdog_err sets (sticky until reset) and the counter saturates.
- Undefined: no counter is built and longp_wdog_err is tied 0.

Test Plan:
- NCH=2, head itag=1, rdwen=1, rdidx=5. Ch0 valid itag=0 and ch1 valid itag=1 data 0xDEADBEEF, out_ready=1 -> only ch1 ready, oitf_ret_ena=1 for that cycle; next cycle o_valid=1, data 0xDEADBEEF, rdidx 5, pend_valid=1.
- Register full and out_ready=0, head rdwen=1 -> ch ready=0, ret_ena=0, outputs held. Raise out_ready -> same-cycle retire, back-to-back valid with new data.
- Register full and stalled, head rdwen=0 with matching channel -> ret_ena=1 immediately, register contents unchanged.
- Both channels valid with itag equal to head -> ch0 wins, longp_multi_hit=1 next cycle and stays 1.
- oitf_empty=1 with channels valid -> all ready=0, ret_ena=0. Assert rst_n low while o_valid=1 -> o_valid, pend_valid and errors drop to 0 asynchronously.
- LONGPWBCK_WDOG_EN, WDOG_LIMIT=4, OITF non-empty, no matching channel for 4 cycles -> longp_wdog_err=1 and stays set after a later retire.
